mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit with private HI/LO registers.
- Sits in the execute stage beside the ALU. Consumes the GRF read_data1/read_data2 operands and produces HI/LO values for mfhi/mflo write-back.
- Models realistic latency with a busy counter, so the control path can stall on a busy MDU.

---
 rtl/mdu_pkg.sv | 59 +++++
 rtl/mdu_if.sv | 28 ++
 rtl/mdu_calc.sv | 111 +++++++++++
 rtl/mdu_unit.sv | 122 ++++++++++++
 tb/tb_mdu_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide unit.
//   - operation encodings (mdu_op_e), read-select constants, counter width
//   - mdu_hilo_t: packed {hi,lo} payload carried between calc and commit logic
//   - op_class(): maps an op code to its execution class (mul/div/move/none)
// Build option: define MDU_MADD_EN to classify MADD/MADDU/MSUB/MSUBU as
// multiply-class ops; otherwise those encodings are illegal.
package mdu_pkg;

  localparam int unsigned MDU_OP_W   = 4;
  localparam int unsigned MDU_DATA_W = 32;
  localparam int unsigned MDU_CNT_W  = 4;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_OP_NONE  = 4'd0,
    MDU_OP_MULT  = 4'd1,
    MDU_OP_MULTU = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_MTHI  = 4'd5,
    MDU_OP_MTLO  = 4'd6,
    MDU_OP_MADD  = 4'd7,
    MDU_OP_MADDU = 4'd8,
    MDU_OP_MSUB  = 4'd9,
    MDU_OP_MSUBU = 4'd10
  } mdu_op_e;

  // Execution class decides latency: mul-class, div-class, immediate move, or no-op.
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_MUL  = 2'd1,
    CLS_DIV  = 2'd2,
    CLS_MOVE = 2'd3
  } mdu_cls_e;

  typedef struct packed {
    logic [MDU_DATA_W-1:0] hi;
    logic [MDU_DATA_W-1:0] lo;
  } mdu_hilo_t;

  function automatic mdu_cls_e op_class(input logic [MDU_OP_W-1:0] op);
    mdu_cls_e cls;
    cls = CLS_NONE;
    case (op)
      MDU_OP_MULT, MDU_OP_MULTU: cls = CLS_MUL;
      MDU_OP_DIV,  MDU_OP_DIVU:  cls = CLS_DIV;
      MDU_OP_MTHI, MDU_OP_MTLO:  cls = CLS_MOVE;
`ifdef MDU_MADD_EN
      MDU_OP_MADD, MDU_OP_MADDU,
      MDU_OP_MSUB, MDU_OP_MSUBU: cls = CLS_MUL;
`endif
      default:                   cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/response bundle between the controller/datapath and the MDU.
//   master (controller side): drives start, mdu_op, rs_data, rt_data, rd_sel
//                             and observes read_data, busy, hi, lo.
//   slave  (mdu_unit side):   the reverse.
interface mdu_if;
  import mdu_pkg::*;

  logic                  start;
  logic [MDU_OP_W-1:0]   mdu_op;
  logic [MDU_DATA_W-1:0] rs_data;
  logic [MDU_DATA_W-1:0] rt_data;
  logic                  rd_sel;
  logic [MDU_DATA_W-1:0] read_data;
  logic                  busy;
  logic [MDU_DATA_W-1:0] hi;
  logic [MDU_DATA_W-1:0] lo;

  modport master (
    output start, mdu_op, rs_data, rt_data, rd_sel,
    input  read_data, busy, hi, lo
  );

  modport slave (
    input  start, mdu_op, rs_data, rt_data, rd_sel,
    output read_data, busy, hi, lo
  );

endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational result generator for the MDU.
//   i_op          operation code (mdu_op_e encoding)
//   i_a, i_b      operands (rs, rt)
//   i_hi, i_lo    currently committed HI/LO (for accumulate and partial moves)
//   o_res_c       next {hi,lo}
//   o_wr_valid_c  1 when the op produces a result to write (0 for divide by
//                 zero and illegal ops)
// Build option: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0]   i_op,
  input  logic [MDU_DATA_W-1:0] i_a,
  input  logic [MDU_DATA_W-1:0] i_b,
  input  logic [MDU_DATA_W-1:0] i_hi,
  input  logic [MDU_DATA_W-1:0] i_lo,
  output mdu_hilo_t             o_res_c,
  output logic                  o_wr_valid_c
);

  logic signed [2*MDU_DATA_W-1:0] w_prod_s;
  logic        [2*MDU_DATA_W-1:0] w_prod_u;
  logic                           w_div_zero;
  logic                           w_div_ovf;
  logic        [MDU_DATA_W-1:0]   w_b_sdiv;
  logic        [MDU_DATA_W-1:0]   w_b_udiv;
  logic signed [MDU_DATA_W-1:0]   w_sq;
  logic signed [MDU_DATA_W-1:0]   w_sr;
  logic        [MDU_DATA_W-1:0]   w_uq;
  logic        [MDU_DATA_W-1:0]   w_ur;

  // Full-width products; operands are extended explicitly to 64 bits.
  assign w_prod_s = $signed({{MDU_DATA_W{i_a[MDU_DATA_W-1]}}, i_a})
                  * $signed({{MDU_DATA_W{i_b[MDU_DATA_W-1]}}, i_b});
  assign w_prod_u = {{MDU_DATA_W{1'b0}}, i_a} * {{MDU_DATA_W{1'b0}}, i_b};

  // The divider never sees 0 or the INT_MIN/-1 overflow pair; those results
  // are overridden below, so the substituted divisor only keeps the arithmetic defined.
  assign w_div_zero = (i_b == '0);
  assign w_div_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  assign w_b_sdiv   = (w_div_zero || w_div_ovf) ? 32'd1 : i_b;
  assign w_b_udiv   = w_div_zero ? 32'd1 : i_b;

  assign w_sq = $signed(i_a) / $signed(w_b_sdiv);
  assign w_sr = $signed(i_a) % $signed(w_b_sdiv);
  assign w_uq = i_a / w_b_udiv;
  assign w_ur = i_a % w_b_udiv;

  // Result select; unselected fields keep the committed values.
  always_comb begin
    o_res_c      = '{hi: i_hi, lo: i_lo};
    o_wr_valid_c = 1'b0;
    case (i_op)
      MDU_OP_MULT: begin
        o_res_c      = mdu_hilo_t'($unsigned(w_prod_s));
        o_wr_valid_c = 1'b1;
      end
      MDU_OP_MULTU: begin
        o_res_c      = mdu_hilo_t'(w_prod_u);
        o_wr_valid_c = 1'b1;
      end
      MDU_OP_DIV: begin
        if (!w_div_zero) begin
          o_wr_valid_c = 1'b1;
          if (w_div_ovf) begin
            o_res_c.lo = i_a;
            o_res_c.hi = '0;
          end else begin
            o_res_c.lo = $unsigned(w_sq);
            o_res_c.hi = $unsigned(w_sr);
          end
        end
      end
      MDU_OP_DIVU: begin
        if (!w_div_zero) begin
          o_wr_valid_c = 1'b1;
          o_res_c.lo   = w_uq;
          o_res_c.hi   = w_ur;
        end
      end
      MDU_OP_MTHI: begin
        o_res_c.hi   = i_a;
        o_wr_valid_c = 1'b1;
      end
      MDU_OP_MTLO: begin
        o_res_c.lo   = i_a;
        o_wr_valid_c = 1'b1;
      end
`ifdef MDU_MADD_EN
      MDU_OP_MADD: begin
        o_res_c      = mdu_hilo_t'({i_hi, i_lo} + $unsigned(w_prod_s));
        o_wr_valid_c = 1'b1;
      end
      MDU_OP_MADDU: begin
        o_res_c      = mdu_hilo_t'({i_hi, i_lo} + w_prod_u);
        o_wr_valid_c = 1'b1;
      end
      MDU_OP_MSUB: begin
        o_res_c      = mdu_hilo_t'({i_hi, i_lo} - $unsigned(w_prod_s));
        o_wr_valid_c = 1'b1;
      end
      MDU_OP_MSUBU: begin
        o_res_c      = mdu_hilo_t'({i_hi, i_lo} - w_prod_u);
        o_wr_valid_c = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with private HI/LO registers.
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    mdu_if.slave:
//            start/mdu_op/rs_data/rt_data  request (sampled when not busy)
//            rd_sel                        0 = LO, 1 = HI for read_data
//            read_data                     combinational view of committed HI/LO
//            busy                          high while an op is in flight
//            hi/lo                         architectural HI/LO registers
// Parameters: MULT_CYCLES (1..15), DIV_CYCLES (1..15) busy latency per class.
// Build option: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (MULT_CYCLES latency).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
)(
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  logic [MDU_DATA_W-1:0] r_hi,      w_hi_nxt;
  logic [MDU_DATA_W-1:0] r_lo,      w_lo_nxt;
  logic [MDU_DATA_W-1:0] r_pend_hi, w_pend_hi_nxt;
  logic [MDU_DATA_W-1:0] r_pend_lo, w_pend_lo_nxt;
  logic                  r_pend_vld, w_pend_vld_nxt;
  logic                  r_busy,     w_busy_nxt;
  logic [MDU_CNT_W-1:0]  r_cnt,      w_cnt_nxt;

  mdu_hilo_t w_calc_res;
  logic      w_calc_vld;
  mdu_cls_e  w_cls;
  logic      w_accept;

  // Result is computed from the operands and committed HI/LO at the start edge.
  mdu_calc u_calc (
    .i_op         (bus.mdu_op),
    .i_a          (bus.rs_data),
    .i_b          (bus.rt_data),
    .i_hi         (r_hi),
    .i_lo         (r_lo),
    .o_res_c      (w_calc_res),
    .o_wr_valid_c (w_calc_vld)
  );

  assign w_cls    = op_class(bus.mdu_op);
  assign w_accept = bus.start & ~r_busy;

  // Next-state: countdown/commit while busy, otherwise accept a new request.
  always_comb begin
    w_hi_nxt       = r_hi;
    w_lo_nxt       = r_lo;
    w_pend_hi_nxt  = r_pend_hi;
    w_pend_lo_nxt  = r_pend_lo;
    w_pend_vld_nxt = r_pend_vld;
    w_busy_nxt     = r_busy;
    w_cnt_nxt      = r_cnt;

    if (r_busy) begin
      w_cnt_nxt = r_cnt - MDU_CNT_W'(1);
      if (r_cnt == MDU_CNT_W'(1)) begin
        w_busy_nxt     = 1'b0;
        w_pend_vld_nxt = 1'b0;
        // Divide by zero leaves pending invalid, so HI/LO are untouched.
        if (r_pend_vld) begin
          w_hi_nxt = r_pend_hi;
          w_lo_nxt = r_pend_lo;
        end
      end
    end else if (w_accept) begin
      case (w_cls)
        CLS_MUL: begin
          w_cnt_nxt      = MDU_CNT_W'(MULT_CYCLES);
          w_busy_nxt     = 1'b1;
          w_pend_hi_nxt  = w_calc_res.hi;
          w_pend_lo_nxt  = w_calc_res.lo;
          w_pend_vld_nxt = w_calc_vld;
        end
        CLS_DIV: begin
          w_cnt_nxt      = MDU_CNT_W'(DIV_CYCLES);
          w_busy_nxt     = 1'b1;
          w_pend_hi_nxt  = w_calc_res.hi;
          w_pend_lo_nxt  = w_calc_res.lo;
          w_pend_vld_nxt = w_calc_vld;
        end
        CLS_MOVE: begin
          w_hi_nxt = w_calc_res.hi;
          w_lo_nxt = w_calc_res.lo;
        end
        default: ;
      endcase
    end
  end

  // State registers; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_pend_hi  <= '0;
      r_pend_lo  <= '0;
      r_pend_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_hi       <= w_hi_nxt;
      r_lo       <= w_lo_nxt;
      r_pend_hi  <= w_pend_hi_nxt;
      r_pend_lo  <= w_pend_lo_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_busy     <= w_busy_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.read_data = (bus.rd_sel == RD_HI) ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: self-checking bench for mdu_unit. A behavioural HI/LO model
// (plain integer arithmetic) supplies expected values and latencies.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mdu_if bus ();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  // Reference model: applies one accepted op to m_hi/m_lo, returns busy cycles.
  function automatic int ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb, lat;
    longint      ps;
    logic [63:0] pu, acc;
    sa  = int'(a);
    sb  = int'(b);
    ps  = longint'(sa) * longint'(sb);
    pu  = {32'd0, a} * {32'd0, b};
    acc = {m_hi, m_lo};
    lat = 0;
    case (op)
      4'd1: begin {m_hi, m_lo} = ps; lat = MC; end
      4'd2: begin {m_hi, m_lo} = pu; lat = MC; end
      4'd3: begin
        lat = DC;
        if (b == 0) begin end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
        else begin m_lo = sa / sb; m_hi = sa - (sa / sb) * sb; end
      end
      4'd4: begin
        lat = DC;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
`ifdef MDU_MADD_EN
      4'd7:  begin {m_hi, m_lo} = acc + ps; lat = MC; end
      4'd8:  begin {m_hi, m_lo} = acc + pu; lat = MC; end
      4'd9:  begin {m_hi, m_lo} = acc - ps; lat = MC; end
      4'd10: begin {m_hi, m_lo} = acc - pu; lat = MC; end
`endif
      default: lat = 0;
    endcase
    return lat;
  endfunction

  // Issue one op (called #1 after an edge) and count busy cycles, bounded.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    bus.start = 1'b1; bus.mdu_op = op; bus.rs_data = a; bus.rt_data = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1; bus.mdu_op = 4'd6; bus.rs_data = 32'hDEAD; bus.rt_data = 32'd0; bus.rd_sel = RD_LO;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; bus.start = 1'b0;
    m_hi = 0; m_lo = 0;
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.read_data !== 32'd0) begin errors++; $display("FAIL reset_rd got %h exp 0", bus.read_data); end
  endtask

  task automatic test_mult();
    int lat, n;
    logic [3:0] op;
    logic [31:0] a, b;
    lat = ref_op(4'd1, 32'hFFFF_FFFE, 32'd3);
    bus.start = 1'b1; bus.mdu_op = 4'd1; bus.rs_data = 32'hFFFF_FFFE; bus.rt_data = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy1 got %b exp 1", bus.busy); end
    repeat (lat - 1) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.lo !== 32'd0) begin errors++; $display("FAIL mult_early got busy %b lo %h exp 1/0", bus.busy, bus.lo); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_end got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_res got %h_%h exp ffffffff_fffffffa", bus.hi, bus.lo); end
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 2));
      a = $urandom; b = $urandom;
      lat = ref_op(op, a, b);
      run_op(op, a, b, n);
      checks++; if (n != lat) begin errors++; $display("FAIL mult_rnd_lat op %0d got %0d exp %0d", op, n, lat); end
      checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL mult_rnd op %0d a %h b %h got %h_%h exp %h_%h", op, a, b, bus.hi, bus.lo, m_hi, m_lo); end
    end
  endtask

  task automatic test_multu();
    int lat, n;
    lat = ref_op(4'd2, 32'hFFFF_FFFF, 32'd2);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, n);
    checks++; if (n != MC) begin errors++; $display("FAIL multu_lat got %0d exp %0d", n, MC); end
    checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_res got %h_%h exp 00000001_fffffffe", bus.hi, bus.lo); end
    bus.rd_sel = RD_HI; #1;
    checks++; if (bus.read_data !== 32'd1) begin errors++; $display("FAIL multu_rd_hi got %h exp 1", bus.read_data); end
    bus.rd_sel = RD_LO; #1;
    checks++; if (bus.read_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_rd_lo got %h exp fffffffe", bus.read_data); end
  endtask

  task automatic test_div();
    int lat, n;
    logic [3:0] op;
    logic [31:0] a, b;
    lat = ref_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
    checks++; if (n != DC) begin errors++; $display("FAIL div_lat got %0d exp %0d", n, DC); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_res got %h_%h exp ffffffff_fffffffd", bus.hi, bus.lo); end
    lat = ref_op(4'd4, 32'd7, 32'd0);
    run_op(4'd4, 32'd7, 32'd0, n);
    checks++; if (n != DC) begin errors++; $display("FAIL divz_lat got %0d exp %0d", n, DC); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divz_res got %h_%h exp ffffffff_fffffffd", bus.hi, bus.lo); end
    lat = ref_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got %h_%h exp 00000000_80000000", bus.hi, bus.lo); end
    for (int i = 0; i < 10; i++) begin
      op = 4'($urandom_range(3, 4));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 100)) : $urandom);
      lat = ref_op(op, a, b);
      run_op(op, a, b, n);
      checks++; if (n != lat) begin errors++; $display("FAIL div_rnd_lat op %0d got %0d exp %0d", op, n, lat); end
      checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL div_rnd op %0d a %h b %h got %h_%h exp %h_%h", op, a, b, bus.hi, bus.lo, m_hi, m_lo); end
    end
  endtask

  task automatic test_move();
    int lat, n;
    lat = ref_op(4'd6, 32'h1234, 32'd0);
    run_op(4'd6, 32'h1234, 32'd0, n);
    checks++; if (n != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got n %0d busy %b exp 0/0", n, bus.busy); end
    checks++; if (bus.lo !== 32'h1234 || bus.hi !== m_hi) begin errors++; $display("FAIL mtlo_res got %h_%h exp %h_00001234", bus.hi, bus.lo, m_hi); end
    lat = ref_op(4'd5, 32'h0BAD_F00D, 32'd0);
    run_op(4'd5, 32'h0BAD_F00D, 32'd0, n);
    checks++; if (bus.hi !== 32'h0BAD_F00D || bus.lo !== 32'h1234 || n != lat) begin errors++; $display("FAIL mthi_res got %h_%h n %0d exp 0badf00d_00001234 n 0", bus.hi, bus.lo, n); end
  endtask

  task automatic test_busy_ignore();
    int lat, n;
    lat = ref_op(4'd1, 32'd3, 32'd5);
    bus.start = 1'b1; bus.mdu_op = 4'd1; bus.rs_data = 32'd3; bus.rt_data = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mdu_op = 4'd5; bus.rs_data = 32'hAAAA;
    @(posedge clk); #1;
    bus.mdu_op = 4'd2; bus.rs_data = 32'hFFFF_FFFF; bus.rt_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 3;
    while (bus.busy === 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n != lat) begin errors++; $display("FAIL ignore_lat got %0d exp %0d", n, lat); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd15) begin errors++; $display("FAIL ignore_res got %h_%h exp 00000000_0000000f", bus.hi, bus.lo); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0) begin errors++; $display("FAIL ignore_after got busy %b hi %h exp 0/0", bus.busy, bus.hi); end
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1; bus.mdu_op = 4'd1; bus.rs_data = 32'h0001_0000; bus.rt_data = 32'h0001_0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid got %h_%h busy %b exp 0_0 busy 0", bus.hi, bus.lo, bus.busy); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_nocommit got %h_%h busy %b exp 0_0 busy 0", bus.hi, bus.lo, bus.busy); end
  endtask

  task automatic test_illegal();
    int lat, n;
    logic [3:0] ops [6];
    ops = '{4'd0, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    lat = ref_op(4'd5, 32'h5555, 32'd0); run_op(4'd5, 32'h5555, 32'd0, n);
    lat = ref_op(4'd6, 32'h6666, 32'd0); run_op(4'd6, 32'h6666, 32'd0, n);
    foreach (ops[i]) begin
      lat = ref_op(ops[i], $urandom, $urandom);
      run_op(ops[i], 32'h1111, 32'h2222, n);
      checks++; if (n != 0 || bus.hi !== 32'h5555 || bus.lo !== 32'h6666) begin errors++; $display("FAIL illegal op %0d got %h_%h n %0d exp 00005555_00006666 n 0", ops[i], bus.hi, bus.lo, n); end
    end
  endtask

  task automatic test_madd();
    int lat, n;
    lat = ref_op(4'd5, 32'd0, 32'd0);           run_op(4'd5, 32'd0, 32'd0, n);
    lat = ref_op(4'd6, 32'hFFFF_FFFF, 32'd0);   run_op(4'd6, 32'hFFFF_FFFF, 32'd0, n);
    lat = ref_op(4'd8, 32'd1, 32'd1);
    run_op(4'd8, 32'd1, 32'd1, n);
`ifdef MDU_MADD_EN
    checks++; if (n != MC) begin errors++; $display("FAIL maddu_lat got %0d exp %0d", n, MC); end
    checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin errors++; $display("FAIL maddu_res got %h_%h exp 00000001_00000000", bus.hi, bus.lo); end
`else
    checks++; if (n != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL maddu_off_busy got n %0d busy %b exp 0", n, bus.busy); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL maddu_off_res got %h_%h exp 00000000_ffffffff", bus.hi, bus.lo); end
`endif
  endtask

  task automatic test_random_mix();
    int lat, n;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom);
      lat = ref_op(op, a, b);
      run_op(op, a, b, n);
      checks++; if (n != lat) begin errors++; $display("FAIL mix_lat op %0d got %0d exp %0d", op, n, lat); end
      bus.rd_sel = 1'($urandom_range(0, 1)); #1;
      checks++; if (bus.read_data !== (bus.rd_sel ? m_hi : m_lo)) begin errors++; $display("FAIL mix_rd op %0d sel %b got %h exp %h", op, bus.rd_sel, bus.read_data, bus.rd_sel ? m_hi : m_lo); end
      checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL mix_res op %0d a %h b %h got %h_%h exp %h_%h", op, a, b, bus.hi, bus.lo, m_hi, m_lo); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_move();
    test_busy_ignore();
    test_reset_mid();
    test_illegal();
    test_madd();
    test_random_mix();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
